// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM state and program-counter function codes for the fetch unit
//
// Contents:
//   fetch_state_t : IDLE (nothing outstanding), REQ (read outstanding),
//                   FLUSH (stale read outstanding, its data will be discarded)
//   ps_t          : program counter function select driven towards the PC register
//   ps_select     : priority encoder for the PC function select

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_LOAD = 2'b10,
        PS_REL  = 2'b11
    } ps_t;

    // A redirect always wins over a sequential advance; PS_REL is never produced.
    function automatic ps_t ps_select(input logic redirect, input logic advance);
        if (redirect) begin
            return PS_LOAD;
        end else if (advance) begin
            return PS_INC;
        end
        return PS_HOLD;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory read port and decode-side instruction stream of the fetch unit
//
// Signals:
//   mem_req    : read request, held until mem_ack
//   mem_addr   : read address, stable while mem_req is high
//   mem_ack    : one-cycle pulse, mem_data valid for the outstanding read
//   mem_data   : returned instruction word
//   inst       : queue head instruction
//   inst_pc    : address of the queue head instruction
//   inst_valid : queue non-empty
//   inst_ready : decode accepts the head when inst_valid is also high
// Modports:
//   master : the fetch unit (drives requests and the instruction stream)
//   slave  : memory plus decode environment

interface fetch_if #(
    parameter int N = 16
);

    logic         mem_req;
    logic [N-1:0] mem_addr;
    logic         mem_ack;
    logic [N-1:0] mem_data;
    logic [N-1:0] inst;
    logic [N-1:0] inst_pc;
    logic         inst_valid;
    logic         inst_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data,
        output inst,
        output inst_pc,
        output inst_valid,
        input  inst_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data,
        input  inst,
        input  inst_pc,
        input  inst_valid,
        output inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - register-based instruction FIFO holding {instruction, address} pairs
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_inst,
//   push_pc             : enqueue one entry (caller never pushes into a full queue
//                         unless it pops in the same cycle)
//   pop                 : dequeue the head; ignored when empty
//   flush               : drop every entry; overrides push and pop in that cycle
//   full, empty, count  : occupancy status
//   head_inst, head_pc  : registered head entry, stale but stable when empty

module fetch_queue #(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [N-1:0]           push_inst,
    input  logic [N-1:0]           push_pc,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [N-1:0]           head_inst,
    output logic [N-1:0]           head_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  inst_mem [DEPTH];
    logic [N-1:0]  pc_mem   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;

    assign do_pop    = pop & ~empty;
    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign count     = cnt;
    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    // At full occupancy a simultaneous push writes the slot being vacated by
    // the pop (wr_ptr == rd_ptr), which becomes the new tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= push_inst;
                pc_mem[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: issues reads at PC, queues returned words, handles redirects
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   pc             : current program counter value (external PC register)
//   ps             : PC function select: hold / +1 / load
//   target         : load value for the PC, zero unless ps is PS_LOAD
//   branch_valid   : one-cycle redirect request from execute
//   branch_target  : redirect address
//   bus            : fetch_if master (memory read port + instruction stream)

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pc,
    output ps_t          ps,
    output logic [N-1:0] target,
    input  logic         branch_valid,
    input  logic [N-1:0] branch_target,
    fetch_if.master      bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    fetch_state_t  state;
    logic          mem_req_q;
    logic          started_q;
    logic [N-1:0]  addr_q;

    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          pop_eff;
    logic          push;
    logic          idle_room;
    logic [CW:0]   occ_after;
    logic          req_room;

    // Only a non-stale response that is not overtaken by a redirect is kept.
    assign push     = (state == ST_REQ) & bus.mem_ack & ~branch_valid;
    assign pop_eff  = bus.inst_ready & ~q_empty;

    // A slot is available for a new read if the queue is not full or the
    // head leaves this cycle.
    assign idle_room = ~q_full | pop_eff;

    // Occupancy after this cycle's pop and push, one bit wider so the
    // arithmetic cannot wrap.
    assign occ_after = {1'b0, q_count} - {{CW{1'b0}}, pop_eff} + {{CW{1'b0}}, push};
    assign req_room  = (occ_after < DEPTH_L);

    always_comb begin
        ps     = ps_select(branch_valid, push);
        target = '0;
        if (branch_valid) begin
            target = branch_target;
        end
    end

    // While waiting in REQ the PC is held, so driving pc straight through is
    // stable. In FLUSH the PC has already been redirected, so the captured
    // address keeps the stale read's address steady until its ack.
    assign bus.mem_addr = (state == ST_REQ) ? pc : addr_q;
    assign bus.mem_req  = mem_req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_req_q <= 1'b0;
            started_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            // One idle cycle after reset release before the first request.
            started_q <= 1'b1;
            if (state == ST_REQ) begin
                addr_q <= pc;
            end
            case (state)
                ST_IDLE: begin
                    // mem_ack here is a leftover from an abandoned read: ignored.
                    if (!branch_valid && started_q && idle_room) begin
                        state     <= ST_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (branch_valid) begin
                        if (bus.mem_ack) begin
                            state     <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            state     <= ST_FLUSH;
                            mem_req_q <= 1'b1;
                        end
                    end else if (bus.mem_ack) begin
                        if (req_room) begin
                            state     <= ST_REQ;
                            mem_req_q <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    // A redirect here only reloads the PC; the stale read is
                    // still outstanding until its ack arrives.
                    if (bus.mem_ack) begin
                        state     <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_inst (bus.mem_data),
        .push_pc   (pc),
        .pop       (pop_eff),
        .flush     (branch_valid),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head_inst (bus.inst),
        .head_pc   (bus.inst_pc)
    );

    assign bus.inst_valid = ~q_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit against a behavioural model

module tb_fetch_unit;

    localparam int N     = 16;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [N-1:0] inst;
        logic [N-1:0] pc;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] pc;
    logic [1:0]   ps;
    logic [N-1:0] target;
    logic         branch_valid;
    logic [N-1:0] branch_target;

    fetch_if #(.N(N)) bus ();

    fetch_unit #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .ps            (ps),
        .target        (target),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;

    ent_t exp_q [$];

    // stimulus knobs (percent / cycles)
    int   p_ready  = 100;
    int   p_branch = 0;
    int   p_stray  = 0;
    int   max_lat  = 0;

    // model state
    logic [N-1:0] pc_model = '0;
    bit   busy      = 0;
    int   wait_cnt  = 0;
    bit   stale     = 0;
    bit   exp_mreq  = 0;
    bit   mreq_known = 0;
    int   rel_cycles = 0;
    bit   mon_en    = 0;
    bit   req_now   = 0;
    bit   ack_drv   = 0;

    // effects of the evaluated cycle, applied after the next rising edge
    bit   pend_flush = 0;
    bit   pend_push  = 0;
    bit   pend_inc   = 0;
    bit   pend_load  = 0;
    ent_t pend_ent;
    logic [N-1:0] pend_tgt;

    function automatic logic [N-1:0] hash(input logic [N-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_pending();
        if (pend_flush) begin
            exp_q.delete();
        end else if (pend_push) begin
            exp_q.push_back(pend_ent);
        end
        if (pend_load) begin
            pc_model = pend_tgt;
        end else if (pend_inc) begin
            pc_model = pc_model + 1'b1;
        end
        pend_flush = 0;
        pend_push  = 0;
        pend_inc   = 0;
        pend_load  = 0;
    endtask

    task automatic drive();
        req_now = bus.mem_req;
        ack_drv = 0;
        if (req_now) begin
            if (!busy) begin
                busy     = 1;
                stale    = 0;
                wait_cnt = int'($urandom_range(0, max_lat));
            end
            if (wait_cnt == 0) begin
                ack_drv = 1;
                busy    = 0;
            end else begin
                wait_cnt--;
            end
        end else if (int'($urandom_range(0, 99)) < p_stray) begin
            ack_drv = 1;
        end
        bus.mem_ack    = ack_drv;
        bus.mem_data   = (ack_drv && req_now) ? hash(bus.mem_addr) : N'($urandom);
        branch_valid   = (int'($urandom_range(0, 99)) < p_branch);
        branch_target  = N'($urandom);
        bus.inst_ready = (int'($urandom_range(0, 99)) < p_ready);
    endtask

    task automatic eval();
        bit           ack_eff;
        bit           acc;
        bit           pop;
        int           size_end;
        logic [1:0]   exp_ps;
        logic [N-1:0] exp_tgt;
        @(negedge clk);
        ack_eff = ack_drv && req_now;
        acc     = ack_eff && !stale && !branch_valid;
        exp_ps  = branch_valid ? 2'b10 : (acc ? 2'b01 : 2'b00);
        exp_tgt = branch_valid ? branch_target : '0;
        check("ps", N'(ps), N'(exp_ps));
        check("target", target, exp_tgt);
        if (mreq_known) begin
            check("mem_req", N'(bus.mem_req), N'(exp_mreq));
        end
        if (req_now && !stale) begin
            check("mem_addr", bus.mem_addr, pc_model);
        end
        pop      = bus.inst_ready && (exp_q.size() > 0);
        size_end = branch_valid ? 0 : exp_q.size() - int'(pop) + int'(acc);
        if (rel_cycles == 0) begin
            exp_mreq = 0;
        end else if (req_now && !ack_eff) begin
            exp_mreq = 1;
        end else if (branch_valid) begin
            exp_mreq = 0;
        end else if (ack_eff && stale) begin
            exp_mreq = 0;
        end else begin
            exp_mreq = (size_end < DEPTH);
        end
        mreq_known = 1;
        if (ack_eff) begin
            stale = 0;
        end else if (req_now && branch_valid) begin
            stale = 1;
        end
        pend_flush = branch_valid;
        pend_push  = acc;
        pend_ent   = '{inst: hash(pc_model), pc: pc_model};
        pend_load  = branch_valid;
        pend_inc   = acc;
        pend_tgt   = branch_target;
        rel_cycles++;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        #1;
        apply_pending();
        pc = pc_model;
        #1;
        drive();
        eval();
    endtask

    task automatic do_reset(input logic [N-1:0] pc_start, input bit set_pc);
        @(posedge clk);
        #1;
        apply_pending();
        mon_en         = 0;
        branch_valid   = 0;
        bus.mem_ack    = 0;
        bus.inst_ready = 0;
        rst_n          = 0;
        #1;
        check("rst_inst_valid", N'(bus.inst_valid), '0);
        check("rst_mem_req", N'(bus.mem_req), '0);
        check("rst_ps", N'(ps), '0);
        check("rst_target", target, '0);
        check("rst_inst", bus.inst, '0);
        check("rst_inst_pc", bus.inst_pc, '0);
        exp_q.delete();
        busy  = 0;
        stale = 0;
        if (set_pc) begin
            pc_model = pc_start;
        end
        pc = pc_model;
        repeat (2) @(posedge clk);
        #1;
        rst_n          = 1;
        mon_en         = 1;
        req_now        = 0;
        ack_drv        = 1;     // stray ack right after release must be ignored
        bus.mem_ack    = 1;
        bus.mem_data   = 16'hDEAD;
        bus.inst_ready = 1;
        rel_cycles     = 0;
        exp_mreq       = 0;
        mreq_known     = 1;
        eval();
    endtask

    // scoreboard monitor: compares the head whenever decode takes it
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("inst_valid", N'(bus.inst_valid), N'(exp_q.size() != 0));
                if (bus.inst_valid && bus.inst_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("inst", bus.inst, e.inst);
                    check("inst_pc", bus.inst_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        pc             = '0;
        branch_valid   = 0;
        branch_target  = '0;
        bus.mem_ack    = 0;
        bus.mem_data   = '0;
        bus.inst_ready = 0;
        #2;

        // sequential fetch from 0x0010, immediate acks, decode always ready
        do_reset(16'h0010, 1);
        p_ready = 100; p_branch = 0; p_stray = 0; max_lat = 0;
        repeat (30) do_cycle();

        // decode stalls: queue fills, fetch must stop, then resume
        p_ready = 0; max_lat = 1;
        repeat (20) do_cycle();
        p_ready = 100;
        repeat (10) do_cycle();

        // fully random traffic with redirects and stray acks
        p_ready = 60; p_branch = 10; p_stray = 10; max_lat = 3;
        repeat (400) do_cycle();

        // reset while a read is outstanding with one entry queued
        p_branch = 100; p_stray = 0;
        do_cycle();
        p_branch = 0; p_ready = 0; max_lat = 2;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            do_cycle();
            if (!pend_flush && (exp_q.size() + int'(pend_push)) == 1 && exp_mreq) begin
                found = 1;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL reset_setup: actual not_reached, required one_entry_with_request");
        end
        do_reset('0, 0);

        p_ready = 50; p_branch = 8; p_stray = 10; max_lat = 3;
        repeat (300) do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, 16, address/instruction width in bits.
REQ-002 Parameter DEPTH, 2, instruction queue entries (power of 2, >=2).
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 PC  in  N  current program counter value.
REQ-006 PS  out  2  program counter function select: 00 hold, 01 +1, 10 load, 11 unused.
REQ-007 target  out  N  load value to program counter (valid when PS=10).
REQ-008 branch_valid  in  1  redirect request from execute, one-cycle pulse.
REQ-009 branch_target  in  N  redirect address, qualified by branch_valid.
REQ-010 mem_req  out  1  instruction memory read request.
REQ-011 mem_addr  out  N  read address, equals PC.
REQ-012 mem_ack  in  1  one-cycle pulse: mem_data valid for the outstanding request.
REQ-013 mem_data  in  N  instruction word returned by memory.
REQ-014 inst  out  N  queue head instruction.
REQ-015 inst_pc  out  N  address of queue head instruction.
REQ-016 inst_valid  out  1  queue non-empty.
REQ-017 inst_ready  in  1  decode accepts head when inst_valid and inst_ready are both high.

Function
REQ-018 FSM states: IDLE (no request outstanding), REQ (request outstanding), FLUSH (stale request outstanding, response to be discarded).
REQ-019 mem_req SHALL be 1 exactly in REQ and FLUSH; mem_addr SHALL equal PC in REQ and hold stable until mem_ack.
REQ-020 IDLE -> REQ when no branch_valid and queue occupancy after this cycle's pop < DEPTH; otherwise stay IDLE.
REQ-021 REQ with mem_ack and no branch: push {mem_data, PC}, PS=01; next state REQ if post-push/pop occupancy < DEPTH, else IDLE.
REQ-022 REQ without mem_ack: PS=00, remain REQ.
REQ-023 branch_valid in any state: PS=10, target=branch_target, queue flushed (occupancy 0 next cycle, same-cycle pop and push discarded).
REQ-024 Branch in REQ without mem_ack -> FLUSH; branch in REQ with mem_ack -> IDLE, ack data dropped; branch in IDLE or FLUSH without ack -> IDLE or FLUSH respectively; branch in FLUSH with ack -> IDLE.
REQ-025 FLUSH with mem_ack and no branch: data dropped, PS=00, -> IDLE; mem_ack in IDLE ignored.
REQ-026 PS SHALL be 00 whenever not set by REQ-021 or REQ-023; target SHALL be 0 when PS!=10.
REQ-027 Queue is FIFO; pop and push in the same cycle SHALL both take effect; occupancy never exceeds DEPTH (guaranteed by REQ-020/021, no overflow path).
REQ-028 inst/inst_pc SHALL be registered queue head; first instruction visible the cycle after its mem_ack.
REQ-029 Pop with inst_valid=0 SHALL be ignored; inst/inst_pc undefined-but-stable when inst_valid=0.

Reset
REQ-030 reset low SHALL asynchronously set state IDLE, occupancy 0, queue pointers 0, inst_valid 0, mem_req 0, PS 00, target 0, inst 0, inst_pc 0.
REQ-031 Reset mid-request SHALL abandon the outstanding read; a mem_ack arriving after release in IDLE is ignored.
REQ-032 First request SHALL issue no earlier than the second rising edge after reset release.

Structure
REQ-033 Shared package fetch_pkg SHALL hold FSM state encoding and PS codes (PS_HOLD, PS_INC, PS_LOAD, PS_REL).
REQ-034 Queue SHALL be a separate sub-module fetch_queue (parameters N, DEPTH; push, pop, flush, full, empty, count).

Verification
REQ-035 PC=0x0010, mem_ack 1 cycle after each req, data 0xA000+i, inst_ready=1 -> inst 0xA000,0xA001,0xA002 with inst_pc 0x0010,0x0011,0x0012, PS=01 on each ack.
REQ-036 inst_ready=0, DEPTH=2 -> two acks accepted, then mem_req=0, PS=00, inst_valid=1 held; raise inst_ready -> fetch resumes next cycle.
REQ-037 branch_valid with branch_target=0x0200 while REQ waits -> PS=10, target=0x0200, queue empty, FLUSH; next ack data dropped; next fetch mem_addr=0x0200.
REQ-038 branch_valid coincident with mem_ack -> data not enqueued, PS=10, state IDLE, next fetch from branch_target.
REQ-039 reset low during REQ with 1 entry queued -> inst_valid=0, mem_req=0, PS=00 immediately; stray mem_ack after release produces no entry.
REQ-040 Simultaneous push and pop at full occupancy 2 -> occupancy stays 2, order preserved, no entry lost.
